// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load widths and the load aligner FSM state.
package riscv_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2,
      MEM_D = 2'd3
   } mem_width_t;

   typedef enum logic [1:0] {
      LA_IDLE    = 2'd0,
      LA_COLLECT = 2'd1,
      LA_DRAIN   = 2'd2
   } load_aligner_state_t;

   // Number of meaningful bytes in a load of the given width.
   function automatic logic [3:0] mem_width_bytes(input mem_width_t width);
      case (width)
         MEM_B:   return 4'd1;
         MEM_H:   return 4'd2;
         MEM_W:   return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/clarvi_load_aligner.sv
// Collects a byte-serial memory response into a buffer, then replays it one
// byte per cycle with zero/sign extension applied for the latched load width.
module clarvi_load_aligner
   import riscv_pkg::*;
#(
   parameter int XLEN_BYTES = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                read_pending,
   input  logic [7:0]          read_data,
   input  logic [2:0]          access_part,
   input  mem_width_t          memory_width,
   input  logic                load_unsigned,
   output logic [7:0]          wb_data,
   output logic [2:0]          wb_part,
   output logic                wb_valid,
   output logic                busy,
   output logic                protocol_error,
   output load_aligner_state_t debug_state
);

   localparam int         IDX_W     = $clog2(XLEN_BYTES);
   localparam logic [2:0] LAST_PART = 3'(XLEN_BYTES - 1);

   // Upstream contract: a response byte is offered with read_pending=1 and is
   // consumed on any rising edge with stall=0; while stall=1 the upstream must
   // hold it. Responses arrive strictly in order, part 0 first.
   load_aligner_state_t state;
   logic [2:0]          expect_part;
   logic [2:0]          drain_part;
   mem_width_t          width_q;
   logic                unsigned_q;
   logic [7:0]          buffer [XLEN_BYTES];

   logic [2:0]          top_idx;
   logic                sign_bit;

   function automatic logic [7:0] extend_byte(input logic [2:0] part,
                                              input mem_width_t width,
                                              input logic zero_ext,
                                              input logic [7:0] data,
                                              input logic sign);
      if ({1'b0, part} < mem_width_bytes(width)) return data;
      if (zero_ext || width == MEM_D) return 8'h00;
      return {8{sign}};
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= LA_IDLE;
         expect_part    <= 3'd0;
         drain_part     <= 3'd0;
         width_q        <= MEM_B;
         unsigned_q     <= 1'b0;
         protocol_error <= 1'b0;
         for (int i = 0; i < XLEN_BYTES; i++) buffer[i] <= 8'h00;
      end else if (!stall) begin
         case (state)
            LA_IDLE: begin
               if (read_pending) begin
                  if (access_part == 3'd0) begin
                     buffer[0]   <= read_data;
                     width_q     <= memory_width;
                     unsigned_q  <= load_unsigned;
                     expect_part <= 3'd1;
                     state       <= LA_COLLECT;
                  end else begin
                     protocol_error <= 1'b1;
                  end
               end
            end
            LA_COLLECT: begin
               if (read_pending) begin
                  if (access_part == expect_part) begin
                     buffer[access_part[IDX_W-1:0]] <= read_data;
                     expect_part                    <= expect_part + 3'd1;
                     if (access_part == LAST_PART) begin
                        state      <= LA_DRAIN;
                        drain_part <= 3'd0;
                     end
                  end else begin
                     // Out-of-order byte: abandon the whole load.
                     protocol_error <= 1'b1;
                     expect_part    <= 3'd0;
                     state          <= LA_IDLE;
                  end
               end
            end
            LA_DRAIN: begin
               if (read_pending) protocol_error <= 1'b1;
               if (drain_part == LAST_PART) begin
                  drain_part <= 3'd0;
                  state      <= LA_IDLE;
               end else begin
                  drain_part <= drain_part + 3'd1;
               end
            end
            default: state <= LA_IDLE;
         endcase
      end
   end

   // The buffer is frozen during DRAIN, so the sign bit cannot change mid-replay.
   assign top_idx  = 3'(mem_width_bytes(width_q) - 4'd1);
   assign sign_bit = buffer[top_idx[IDX_W-1:0]][7];

   assign wb_valid    = (state == LA_DRAIN);
   assign wb_part     = wb_valid ? drain_part : 3'd0;
   assign wb_data     = wb_valid ? extend_byte(drain_part, width_q, unsigned_q,
                                               buffer[drain_part[IDX_W-1:0]], sign_bit)
                                 : 8'h00;
   assign busy        = (state != LA_IDLE);
   assign debug_state = state;

endmodule
